// File: rtl/noc_traffic_pe.sv
// noc_traffic_pe: per-node traffic generator and monitor for one router PE port.
// The transmit side forms packets from a token-paced, back-pressure-aware FSM
// and a selectable destination pattern. The receive side accumulates latency
// statistics and flags packets that arrive at the wrong node.
//
// Ports:
//   clk, rst                clock, asynchronous active-high reset
//   start, enable           both high permit generation (level)
//   mode[1:0]               0 random, 1 transpose, 2 bit-complement, 3 hotspot
//   r_valid_pe/r_data_pe    registered packet toward the router
//   r_ready_pe              router accepts
//   w_valid_pe/w_data_pe    packet from the router (always accepted)
//   done                    every packet has been handed to the router (sticky)
//   sent_count, recv_count  handshake and receive counters
//   latency_sum/max         receive latency statistics (now - timestamp)
//   misroute                sticky: a received packet was not addressed here
module noc_traffic_pe #(
  parameter int          X           = 3,
  parameter int          Y           = 5,
  parameter int          x_size      = $clog2(X),
  parameter int          y_size      = $clog2(Y),
  parameter int          data_width  = 256,
  parameter int          MY_X        = 0,
  parameter int          MY_Y        = 0,
  parameter int          NUM_PACKETS = 1000,
  parameter int          RATE        = 1,
  parameter int          HOT_X       = 0,
  parameter int          HOT_Y       = 0,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic                                 enable,
  input  logic [1:0]                           mode,
  output logic                                 r_valid_pe,
  output logic [x_size+y_size+data_width-1:0]  r_data_pe,
  input  logic                                 r_ready_pe,
  input  logic                                 w_valid_pe,
  input  logic [x_size+y_size+data_width-1:0]  w_data_pe,
  output logic                                 done,
  output logic [31:0]                          sent_count,
  output logic [31:0]                          recv_count,
  output logic [47:0]                          latency_sum,
  output logic [31:0]                          latency_max,
  output logic                                 misroute
);

  localparam int          HW        = x_size + y_size;
  localparam int          PW        = HW + data_width;
  localparam int          CW        = (RATE > 1) ? $clog2(RATE) : 1;
  localparam logic [15:0] SEED_MIX  = SEED ^ 16'(MY_Y * X + MY_X);
  // An all-zero Galois LFSR would lock up, so a zero seed becomes 1.
  localparam logic [15:0] LFSR_INIT = (SEED_MIX == 16'd0) ? 16'd1 : SEED_MIX;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t          r_state, w_state_d;
  logic [31:0]     r_now;
  logic [15:0]     r_lfsr;
  logic [CW-1:0]   r_cnt;
  logic            r_token;
  logic [16:0]     r_seq;

  logic            w_hs, w_go, w_wrap, w_form;
  int              w_tx, w_ty;
  logic [PW-1:0]   w_pkt;
  logic [31:0]     w_lat;
  logic            w_rx_here;
  logic            w_unused;

  assign w_hs   = r_valid_pe & r_ready_pe;
  assign w_go   = start & enable;
  assign w_wrap = (r_cnt == CW'(RATE - 1));

  // Formation needs the token and a free output slot; a slot handing off this
  // cycle counts as free so RATE=1 streams back-to-back.
  always_comb begin
    w_state_d = r_state;
    w_form    = 1'b0;
    case (r_state)
      S_IDLE:  if (w_go) w_state_d = S_RUN;
      S_RUN: begin
        if (!w_go) w_state_d = S_IDLE;
        else if (r_token && (!r_valid_pe || w_hs)) begin
          w_form = 1'b1;
          if (r_seq == 17'(NUM_PACKETS - 1)) w_state_d = S_DRAIN;
        end
      end
      // Only the last packet can still be in the register here.
      S_DRAIN: if (w_hs) w_state_d = S_DONE;
      default: w_state_d = r_state;
    endcase
  end

  // Destination choice; never address ourselves.
  always_comb begin
    w_tx = 0;
    w_ty = 0;
    case (mode)
      2'd0:    begin w_tx = int'(r_lfsr[7:0]) % X; w_ty = int'(r_lfsr[15:8]) % Y; end
      2'd1:    begin w_tx = MY_Y % X;              w_ty = MY_X % Y;               end
      2'd2:    begin w_tx = X - 1 - MY_X;          w_ty = Y - 1 - MY_Y;           end
      default: begin w_tx = HOT_X;                 w_ty = HOT_Y;                  end
    endcase
    if (w_tx == MY_X && w_ty == MY_Y) w_tx = (MY_X + 1) % X;
  end

  always_comb begin
    w_pkt                              = '0;
    w_pkt[x_size-1:0]                  = x_size'(w_tx);
    w_pkt[HW-1:x_size]                 = y_size'(w_ty);
    w_pkt[HW +: 32]                    = r_now;
    w_pkt[HW+32 +: 16]                 = r_seq[15:0];
    w_pkt[HW+48 +: x_size]             = x_size'(MY_X);
    w_pkt[HW+48+x_size +: y_size]      = y_size'(MY_Y);
  end

  assign w_lat     = r_now - w_data_pe[HW +: 32];
  assign w_rx_here = (w_data_pe[x_size-1:0] == x_size'(MY_X)) &&
                     (w_data_pe[HW-1:x_size] == y_size'(MY_Y));
  assign w_unused  = ^w_data_pe[PW-1:HW+32];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_now       <= '0;
      r_lfsr      <= LFSR_INIT;
      r_cnt       <= '0;
      r_token     <= 1'b0;
      r_seq       <= '0;
      r_valid_pe  <= 1'b0;
      r_data_pe   <= '0;
      done        <= 1'b0;
      sent_count  <= '0;
      recv_count  <= '0;
      latency_sum <= '0;
      latency_max <= '0;
      misroute    <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_now   <= r_now + 32'd1;
      r_lfsr  <= r_lfsr[0] ? ({1'b0, r_lfsr[15:1]} ^ 16'hB400) : {1'b0, r_lfsr[15:1]};
      r_cnt   <= w_wrap ? '0 : r_cnt + 1'b1;
      // A fresh interval wins over consumption, so the token never banks
      // more than one opportunity yet RATE=1 stays saturated.
      if (w_wrap)      r_token <= 1'b1;
      else if (w_form) r_token <= 1'b0;

      if (w_form) begin
        r_valid_pe <= 1'b1;
        r_data_pe  <= w_pkt;
        r_seq      <= r_seq + 17'd1;
      end else if (w_hs) begin
        r_valid_pe <= 1'b0;
      end

      if (w_hs) sent_count <= sent_count + 32'd1;
      done <= (w_state_d == S_DONE);

      if (w_valid_pe) begin
        recv_count  <= recv_count + 32'd1;
        latency_sum <= latency_sum + {16'd0, w_lat};
        if (w_lat > latency_max) latency_max <= w_lat;
        if (!w_rx_here) misroute <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_noc_traffic_pe.sv
module tb_noc_traffic_pe;
  localparam int DW = 64;
  localparam int HW = 5;
  localparam int PW = HW + DW;
  localparam int MYX [2] = '{1, 1};
  localparam int MYY [2] = '{2, 1};
  localparam int HX  [2] = '{0, 2};
  localparam int HY  [2] = '{0, 3};
  localparam int NP  [2] = '{4, 20};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]          st = '0, en = '0, rdy = '0, wv = '0;
  logic [1:0][1:0]     md = '0;
  logic [1:0][PW-1:0]  wd = '0;
  logic [1:0]          va, dn, mis;
  logic [1:0][PW-1:0]  rd;
  logic [1:0][31:0]    sc, rc, lmax;
  logic [1:0][47:0]    lsum;

  noc_traffic_pe #(.X(3), .Y(5), .data_width(DW), .MY_X(1), .MY_Y(2),
                   .NUM_PACKETS(4), .RATE(1)) u_a (
    .clk(clk), .rst(rst), .start(st[0]), .enable(en[0]), .mode(md[0]),
    .r_valid_pe(va[0]), .r_data_pe(rd[0]), .r_ready_pe(rdy[0]),
    .w_valid_pe(wv[0]), .w_data_pe(wd[0]), .done(dn[0]), .sent_count(sc[0]),
    .recv_count(rc[0]), .latency_sum(lsum[0]), .latency_max(lmax[0]), .misroute(mis[0]));

  noc_traffic_pe #(.X(3), .Y(5), .data_width(DW), .MY_X(1), .MY_Y(1),
                   .NUM_PACKETS(20), .RATE(4), .HOT_X(2), .HOT_Y(3)) u_b (
    .clk(clk), .rst(rst), .start(st[1]), .enable(en[1]), .mode(md[1]),
    .r_valid_pe(va[1]), .r_data_pe(rd[1]), .r_ready_pe(rdy[1]),
    .w_valid_pe(wv[1]), .w_data_pe(wd[1]), .done(dn[1]), .sent_count(sc[1]),
    .recv_count(rc[1]), .latency_sum(lsum[1]), .latency_max(lmax[1]), .misroute(mis[1]));

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [15:0] seed_of(input int i);
    logic [15:0] s;
    s = 16'hACE1 ^ 16'(MYY[i] * 3 + MYX[i]);
    return (s == 16'd0) ? 16'd1 : s;
  endfunction

  function automatic logic [15:0] lstep(input logic [15:0] l);
    return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
  endfunction

  function automatic logic [4:0] exp_hdr(input int i, input logic [1:0] m, input logic [15:0] l);
    int x, y;
    case (m)
      2'd0:    begin x = int'(l[7:0]) % 3; y = int'(l[15:8]) % 5; end
      2'd1:    begin x = MYY[i] % 3;       y = MYX[i] % 5;        end
      2'd2:    begin x = 2 - MYX[i];       y = 4 - MYY[i];        end
      default: begin x = HX[i];            y = HY[i];             end
    endcase
    if (x == MYX[i] && y == MYY[i]) x = (MYX[i] + 1) % 3;
    return {3'(y), 2'(x)};
  endfunction

  logic [31:0]      now_m;
  logic [1:0][15:0] lfsr_m;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      now_m <= '0;
      for (int i = 0; i < 2; i++) lfsr_m[i] <= seed_of(i);
    end else begin
      now_m <= now_m + 32'd1;
      for (int i = 0; i < 2; i++) lfsr_m[i] <= lstep(lfsr_m[i]);
    end
  end

  logic [15:0]   lh [2][4096];
  logic [1:0]    mh [2][4096];
  int            exp_sent [2];
  logic [31:0]   last_ts [2];
  logic          have_ts [2];
  logic          stall [2];
  logic [PW-1:0] held [2];
  int            e_rc [2];
  logic [47:0]   e_sum [2];
  logic [31:0]   e_max [2];
  logic          e_mis [2];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        exp_sent[i] = 0; have_ts[i] = 1'b0; stall[i] = 1'b0;
        e_rc[i] = 0; e_sum[i] = '0; e_max[i] = '0; e_mis[i] = 1'b0;
      end else begin
        logic [PW-1:0] p;
        logic [31:0]   ts, lat;
        lh[i][now_m[11:0]] = lfsr_m[i];
        mh[i][now_m[11:0]] = md[i];
        chk("sent_count", sc[i], exp_sent[i]);
        chk("done", dn[i], exp_sent[i] == NP[i]);
        chk("recv_count", rc[i], e_rc[i]);
        chk("latency_sum", lsum[i], e_sum[i]);
        chk("latency_max", lmax[i], e_max[i]);
        chk("misroute", mis[i], e_mis[i]);
        if (stall[i]) begin
          chk("hold_valid", va[i], 1'b1);
          chk("hold_data", rd[i], held[i]);
        end
        if (exp_sent[i] == NP[i]) chk("valid_after_done", va[i], 1'b0);
        stall[i] = va[i] && !rdy[i];
        held[i]  = rd[i];
        if (va[i] && rdy[i]) begin
          p  = rd[i];
          ts = p[HW +: 32];
          chk("seq", p[HW+32 +: 16], 16'(exp_sent[i]));
          chk("ts_past", ts < now_m, 1'b1);
          if (have_ts[i]) chk("ts_order", ts > last_ts[i], 1'b1);
          chk("dest", p[4:0], exp_hdr(i, mh[i][ts[11:0]], lh[i][ts[11:0]]));
          chk("src", p[HW+48 +: 5], {3'(MYY[i]), 2'(MYX[i])});
          chk("pad", p[PW-1:HW+53], 0);
          last_ts[i] = ts; have_ts[i] = 1'b1;
          exp_sent[i]++;
        end
        if (wv[i]) begin
          lat = now_m - wd[i][HW +: 32];
          e_rc[i]++;
          e_sum[i] = e_sum[i] + {16'd0, lat};
          if (lat > e_max[i]) e_max[i] = lat;
          if (wd[i][4:0] != {3'(MYY[i]), 2'(MYX[i])}) e_mis[i] = 1'b1;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_reset;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  function automatic logic [PW-1:0] rx_pkt(input logic [31:0] nw);
    logic [PW-1:0] p;
    p = PW'({$urandom, $urandom, $urandom});
    if ($urandom_range(0, 3) == 0) p[4:0] = {3'($urandom_range(0, 4)), 2'($urandom_range(0, 2))};
    else                           p[4:0] = {3'd1, 2'd1};
    if ($urandom_range(0, 7) == 0) p[HW +: 32] = $urandom;
    else                           p[HW +: 32] = nw - $urandom_range(0, 5000);
    return p;
  endfunction

  task automatic rand_run(input int i, input int maxcyc);
    st[i] = 1'b1; en[i] = 1'b1;
    do_reset;
    for (int c = 0; c < maxcyc && !dn[i]; c++) begin
      @(posedge clk); #1;
      md[i]  = 2'($urandom_range(0, 3));
      rdy[i] = ($urandom_range(0, 3) != 0);
      en[i]  = ($urandom_range(0, 9) != 0);
      if (i == 1) begin
        wv[1] = ($urandom_range(0, 2) == 0);
        wd[1] = rx_pkt(now_m);
      end
    end
    wv[1] = 1'b0;
    @(negedge clk);
    chk("rand_done", dn[i], 1'b1);
    st[i] = 1'b0;
  endtask

  initial begin
    logic [PW-1:0] cap, p;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", va, 2'b00);
    chk("rst_done", dn, 2'b00);
    chk("rst_sent", {sc[1], sc[0]}, 0);
    chk("rst_data", {rd[1], rd[0]}, 0);

    // A: transpose, ready high -> four back-to-back packets to (2,1)
    st[0] = 1; en[0] = 1; md[0] = 2'd1; rdy[0] = 1;
    do_reset;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("tp_valid", va[0], 1'b1);
      chk("tp_dest", rd[0][4:0], {3'd1, 2'd2});
      chk("tp_seq", rd[0][HW+32 +: 16], k);
      chk("tp_ts", rd[0][HW +: 32], k + 1);
      if (k == 3) chk("tp_done_early", dn[0], 1'b0);
    end
    @(negedge clk);
    chk("tp_done", dn[0], 1'b1);
    chk("tp_sent", sc[0], 4);
    chk("tp_valid_end", va[0], 1'b0);

    // A: bit-complement lands on self -> redirected to (2,2)
    md[0] = 2'd2;
    do_reset;
    repeat (3) @(negedge clk);
    chk("bc_valid", va[0], 1'b1);
    chk("bc_dest", rd[0][4:0], {3'd2, 2'd2});

    // A: ready low for 10 cycles, data must hold
    md[0] = 2'd0; rdy[0] = 0;
    do_reset;
    repeat (3) @(negedge clk);
    cap = rd[0];
    chk("stall_valid", va[0], 1'b1);
    chk("stall_dest", cap[4:0], exp_hdr(0, 2'd0, lh[0][1]));
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("stall_data", rd[0], cap);
      chk("stall_sent", sc[0], 0);
    end
    @(posedge clk); #1 rdy[0] = 1;
    for (int k = 0; k < 20 && !dn[0]; k++) @(negedge clk);
    chk("stall_done", dn[0], 1'b1);
    chk("stall_sent_end", sc[0], 4);

    // A: reset mid-run with valid held, then restart
    md[0] = 2'd0; rdy[0] = 0;
    do_reset;
    repeat (4) @(negedge clk);
    chk("rr_valid1", va[0], 1'b1);
    chk("rr_dest1", rd[0][4:0], exp_hdr(0, 2'd0, lh[0][1]));
    @(posedge clk); #1 rst = 1'b1;
    #1;
    chk("rr_out_valid", va[0], 1'b0);
    chk("rr_out_data", rd[0], 0);
    chk("rr_out_stats", {sc[0], rc[0], lmax[0], lsum[0], dn[0], mis[0]}, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rr_idle", va[0], 1'b0);
    repeat (3) @(negedge clk);
    chk("rr_valid2", va[0], 1'b1);
    chk("rr_ts2", rd[0][HW +: 32], 1);
    chk("rr_dest2", rd[0][4:0], exp_hdr(0, 2'd0, lh[0][1]));

    // A: randomized run
    rand_run(0, 200);
    st[0] = 0; rdy[0] = 0;

    // B: RATE=4 hotspot, pulses exactly 4 cycles apart
    st[1] = 1; en[1] = 1; md[1] = 2'd3; rdy[1] = 1;
    do_reset;
    for (int k = 0; k <= 20; k++) begin
      @(negedge clk);
      chk("r4_valid", va[1], (k >= 5) && (k % 4 == 1));
      if (va[1]) chk("r4_ts", rd[1][HW +: 32], k - 1);
    end

    // B: long stall must not bank extra tokens
    rdy[1] = 0;
    do_reset;
    repeat (5) @(negedge clk);
    for (int k = 5; k <= 15; k++) begin
      @(negedge clk);
      if (k == 5) begin
        cap = rd[1];
        chk("bk_ts", cap[HW +: 32], 4);
      end
      chk("bk_hold", rd[1], cap);
      chk("bk_sent", sc[1], 0);
    end
    @(posedge clk); #1 rdy[1] = 1;
    @(negedge clk);
    chk("bk_v16", va[1], 1'b1);
    @(negedge clk);
    chk("bk_v17", va[1], 1'b1);
    chk("bk_ts17", rd[1][HW +: 32], 16);
    chk("bk_sent17", sc[1], 1);
    for (int k = 18; k <= 20; k++) begin
      @(negedge clk);
      chk("bk_gap", va[1], 1'b0);
    end
    @(negedge clk);
    chk("bk_v21", va[1], 1'b1);
    chk("bk_ts21", rd[1][HW +: 32], 20);

    // B: receive latency and misroute
    st[1] = 0; rdy[1] = 0;
    do_reset;
    @(posedge clk); #1;
    p = '0; p[4:0] = {3'd1, 2'd1}; p[HW +: 32] = now_m - 32'd7;
    wv[1] = 1; wd[1] = p;
    @(posedge clk); #1;
    p = '0; p[HW +: 32] = now_m;
    wd[1] = p;
    @(negedge clk);
    chk("rx1_count", rc[1], 1);
    chk("rx1_max", lmax[1], 7);
    chk("rx1_mis", mis[1], 1'b0);
    @(posedge clk); #1 wv[1] = 0;
    @(negedge clk);
    chk("rx2_count", rc[1], 2);
    chk("rx2_max", lmax[1], 7);
    chk("rx2_sum", lsum[1], 7);
    chk("rx2_mis", mis[1], 1'b1);

    // B: randomized run with concurrent receive traffic
    rand_run(1, 600);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/noc_traffic_pe.md
# noc_traffic_pe

Synthesizable per-node traffic generator and monitor for `openNocTop`, one instance per mesh node. It supersedes the fixed-pattern random PE with these additions:
- runtime-selectable destination pattern (random, transpose, bit-complement, hotspot);
- a parametrised injection interval;
- back-pressure-aware injection;
- per-node latency statistics and misroute detection.

It connects to one router's PE port and can run on FPGA without testbench support.

## Interface
Parameters:
- X, 3, mesh columns
- Y, 5, mesh rows
- x_size, $clog2(X), header x-field width
- y_size, $clog2(Y), header y-field width
- data_width, 256, payload width; must be ≥ 48+x_size+y_size
- MY_X, 0, this node's column
- MY_Y, 0, this node's row
- NUM_PACKETS, 1000, packets to inject (1..2^16)
- RATE, 1, cycles per injection opportunity (≥1)
- HOT_X, 0, hotspot column
- HOT_Y, 0, hotspot row
- SEED, 16'hACE1, LFSR seed; XORed with MY_Y*X+MY_X, forced to 1 if result is 0

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  level: permit packet generation
- enable  in  1  per-node send enable
- mode  in  2  0 RANDOM, 1 TRANSPOSE, 2 BIT_COMPLEMENT, 3 HOTSPOT; sampled when each packet is formed
- r_valid_pe  out  1  packet valid toward router
- r_data_pe  out  x_size+y_size+data_width  packet toward router
- r_ready_pe  in  1  router accepts
- w_valid_pe  in  1  packet from router (no back-pressure)
- w_data_pe  in  x_size+y_size+data_width  packet from router
- done  out  1  all NUM_PACKETS handed to router
- sent_count  out  32  accepted handshakes
- recv_count  out  32  packets received
- latency_sum  out  48  sum of receive latencies
- latency_max  out  32  largest single latency
- misroute  out  1  sticky: received packet not addressed here

## Operation
- Packet format, LSB first:
  - dest x [x_size-1:0], then dest y [y_size-1:0];
  - payload bits [31:0] = injection timestamp, [47:32] = sequence number, then src x, src y; remaining payload bits zero.
- Free-running 32-bit cycle counter `now`, cleared by rst, wraps at 2^32.
- LFSR: 16-bit Galois, mask 16'hB400, advances every cycle after reset.
- Destination per mode:
  - RANDOM: x = lfsr[7:0] % X, y = lfsr[15:8] % Y.
  - TRANSPOSE: (MY_Y % X, MY_X % Y).
  - BIT_COMPLEMENT: (X-1-MY_X, Y-1-MY_Y).
  - HOTSPOT: (HOT_X, HOT_Y).
  - If the result equals (MY_X, MY_Y), in every mode, dest x becomes (MY_X+1) % X.
- Interval counter runs 0..RATE-1 and wraps. At wrap it sets a single token (tokens do not accumulate); the token clears when a packet is formed.
- FSM:
  - IDLE: go to RUN when start & enable.
  - RUN: form a packet when token set and output register empty or handshaking this cycle. Sequence increments per formed packet. After the NUM_PACKETS-th is formed, go to DRAIN. If start or enable drops, return to IDLE; a held packet still completes; counts are preserved.
  - DRAIN: go to DONE on the final handshake.
  - DONE: sticky until rst.
- Receive side, on each w_valid_pe cycle:
  - recv_count+1;
  - lat = now − timestamp (mod 2^32); latency_sum += lat; latency_max = max(latency_max, lat);
  - if dest field ≠ (MY_X, MY_Y), set misroute; the packet is still counted.

## Timing
- Reset values: all outputs 0; FSM IDLE; token 0; LFSR at seeded value.
- Formation: r_valid_pe/r_data_pe are registered and assert the cycle after the formation condition holds. The timestamp records `now` at formation.
- Handshake: transfer on r_valid_pe & r_ready_pe. While valid & !ready, data is held stable. Valid never drops without a transfer, except on rst.
- Throughput: with RATE=1 and ready held high, one packet per cycle back-to-back (reload in the handshake cycle).
- sent_count increments in the cycle after the handshake edge.
- done rises the cycle after the final handshake.
- Receive statistics update one cycle after w_valid_pe.
- Simultaneous receive and send: independent, no conflict.
- rst asserted mid-operation: all state clears immediately; any in-flight packet is dropped.

## Test plan
- RATE=1, TRANSPOSE, NUM_PACKETS=4, MY=(1,2), ready=1 → four consecutive valids, dest (2%3=2, 1), seq 0..3; done 1 cycle after the 4th handshake; sent_count=4.
- RATE=4, ready=1 → valid pulses spaced exactly 4 cycles apart; timestamps differ by 4.
- Ready low for 10 cycles during RUN → r_data_pe stable throughout; no extra token banked; sent_count unchanged until ready rises.
- BIT_COMPLEMENT at MY=(1,2) on 3x5 → dest (1,2) equals self → redirected to (2,2).
- Inject w_valid_pe with timestamp now−7 addressed here, then one addressed to (0,0) at MY=(1,1) → recv_count=2, latency_max ≥ 7, misroute=1.
- Assert rst for 1 cycle in RUN with valid held high and ready low → all outputs 0 the following cycle; FSM IDLE; restart reproduces the same first LFSR destination.
